cascade_parity_responder: RTL and testbench

Answers block-parity queries issued during cascade error reconciliation. A query names a pass and a contiguous index range. The block returns the XOR of those bits taken from the key as permuted for that pass.
- Pass 1 uses the unshuffled key; passes 2-4 use the per-pass shuffled keys produced by the shuffle logic.
- Sits between the shuffle network and the reconciliation protocol controller.
- Computes parity serially over a latched key snapshot so that long ranges do not create a wide combinational XOR tree.

---
 rtl/cascade_parity_responder.sv | 188 ++++++++++++++++++
 tb/tb_cascade_parity_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cascade_parity_responder.sv
// cascade_parity_responder: answers block-parity queries over a latched
// snapshot of the four per-pass cascade keys. Parity is folded BPC bits per
// cycle so long ranges never build a wide XOR tree.
// Optional feature macro: CASCADE_QUERY_CNT_EN (adds the 16-bit query_cnt output).
module cascade_parity_responder #(
   parameter int unsigned KEY_LEN = 64,
   parameter int unsigned IDX_W   = 7,
   parameter int unsigned BPC     = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_load,
   output logic               key_ready,
   input  logic [KEY_LEN-1:0] key_p1,
   input  logic [KEY_LEN-1:0] key_p2,
   input  logic [KEY_LEN-1:0] key_p3,
   input  logic [KEY_LEN-1:0] key_p4,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_pass,
   input  logic [IDX_W-1:0]   req_start,
   input  logic [IDX_W-1:0]   req_len,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic               rsp_parity,
   output logic               rsp_err,
   output logic [1:0]         rsp_pass
`ifdef CASCADE_QUERY_CNT_EN
   ,
   output logic [15:0]        query_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(BPC + 1);
   localparam int unsigned SUM_W = IDX_W + 1;
   localparam int unsigned PAD_W = KEY_LEN + BPC;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]               rst_pipe;
   logic                     rst_int_n;

   logic [1:0]               state_q, state_d;
   logic [IDX_W-1:0]         ptr_q, ptr_d;
   logic [IDX_W-1:0]         rem_q, rem_d;
   logic                     acc_q, acc_d;
   logic [1:0]               pass_d;
   logic                     parity_d;
   logic                     err_d;
   logic                     valid_d;
   logic [3:0][KEY_LEN-1:0]  snap_q;

   logic                     load_acc;
   logic                     req_acc;
   logic [SUM_W-1:0]         range_end;
   logic                     range_bad;
   logic [KEY_LEN-1:0]       snap_sel;
   logic [PAD_W-1:0]         snap_pad;
   logic [BPC-1:0]           window;
   logic [CNT_W-1:0]         take;
   logic [BPC-1:0]           mask;
   logic                     fold;
   logic                     last_chunk;

   // Reset synchroniser: assertion is immediate, release aligned to clk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= 2'b00;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_int_n = rst_pipe[1];

   assign key_ready = (state_q == S_IDLE);
   assign req_ready = key_ready & ~key_load;
   assign load_acc  = key_ready & key_load;
   assign req_acc   = key_ready & ~key_load & req_valid;

   // Range check is done one bit wider so start+len cannot wrap
   assign range_end = SUM_W'(req_start) + SUM_W'(req_len);
   assign range_bad = (req_len == '0) || (range_end > SUM_W'(KEY_LEN));

   // Chunk extraction: zero-padded so a window past the key top reads zeros
   assign snap_sel   = snap_q[rsp_pass];
   assign snap_pad   = {BPC'(0), snap_sel};
   assign window     = snap_pad[ptr_q +: BPC];
   assign last_chunk = (rem_q <= IDX_W'(BPC));
   assign take       = last_chunk ? CNT_W'(rem_q) : CNT_W'(BPC);
   assign mask       = ~({BPC{1'b1}} << take);
   assign fold       = ^(window & mask);

   // Key snapshot: only captured while idle
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         snap_q <= '0;
      end else if (load_acc) begin
         snap_q <= {key_p4, key_p3, key_p2, key_p1};
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      rem_d    = rem_q;
      acc_d    = acc_q;
      pass_d   = rsp_pass;
      parity_d = rsp_parity;
      err_d    = rsp_err;
      valid_d  = rsp_valid;
      case (state_q)
         S_IDLE: begin
            if (req_acc) begin
               pass_d = req_pass;
               if (range_bad) begin
                  state_d  = S_RESP;
                  valid_d  = 1'b1;
                  err_d    = 1'b1;
                  parity_d = 1'b0;
               end else begin
                  state_d = S_CALC;
                  acc_d   = 1'b0;
                  ptr_d   = req_start;
                  rem_d   = req_len;
               end
            end
         end
         S_CALC: begin
            acc_d = acc_q ^ fold;
            ptr_d = ptr_q + IDX_W'(BPC);
            rem_d = rem_q - IDX_W'(take);
            if (last_chunk) begin
               state_d  = S_RESP;
               valid_d  = 1'b1;
               err_d    = 1'b0;
               parity_d = acc_q ^ fold;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
            valid_d = 1'b0;
         end
      endcase
   end

   // State, datapath and response registers
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         rem_q      <= '0;
         acc_q      <= 1'b0;
         rsp_pass   <= 2'b00;
         rsp_parity <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_valid  <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         rem_q      <= rem_d;
         acc_q      <= acc_d;
         rsp_pass   <= pass_d;
         rsp_parity <= parity_d;
         rsp_err    <= err_d;
         rsp_valid  <= valid_d;
      end
   end

`ifdef CASCADE_QUERY_CNT_EN
   // Saturating count of accepted requests, cleared by an accepted key load
   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         query_cnt <= 16'h0000;
      end else if (load_acc) begin
         query_cnt <= 16'h0000;
      end else if (req_acc && (query_cnt != 16'hFFFF)) begin
         query_cnt <= query_cnt + 16'h0001;
      end
   end
`endif

endmodule

// File: tb/tb_cascade_parity_responder.sv
// Directed self-checking bench for cascade_parity_responder.
module tb_cascade_parity_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        key_load;
   logic        key_ready;
   logic [63:0] key_p1, key_p2, key_p3, key_p4;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_pass;
   logic [6:0]  req_start;
   logic [6:0]  req_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_parity;
   logic        rsp_err;
   logic [1:0]  rsp_pass;
`ifdef CASCADE_QUERY_CNT_EN
   logic [15:0] query_cnt;
`endif

   int n_cmp = 0;
   int n_mis = 0;
   int lat;

   cascade_parity_responder #(.KEY_LEN(64), .IDX_W(7), .BPC(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_load   (key_load),
      .key_ready  (key_ready),
      .key_p1     (key_p1),
      .key_p2     (key_p2),
      .key_p3     (key_p3),
      .key_p4     (key_p4),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_pass   (req_pass),
      .req_start  (req_start),
      .req_len    (req_len),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_parity (rsp_parity),
      .rsp_err    (rsp_err),
      .rsp_pass   (rsp_pass)
`ifdef CASCADE_QUERY_CNT_EN
      ,
      .query_cnt  (query_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Snapshot all four keys; a simultaneous request must not be taken
   task automatic load_keys(input logic [63:0] k1, k2, k3, k4);
      @(negedge clk);
      key_p1 = k1; key_p2 = k2; key_p3 = k3; key_p4 = k4;
      key_load  = 1'b1;
      req_valid = 1'b1; req_pass = 2'd0; req_start = 7'd0; req_len = 7'd8;
      #1;
      check("load_req_ready_masked", 32'(req_ready), 0);
      @(posedge clk); #1;
      key_load = 1'b0; req_valid = 1'b0;
      key_p1 = ~k1; key_p2 = ~k2; key_p3 = ~k3; key_p4 = ~k4;
      check("load_no_accept", 32'(key_ready), 1);
   endtask

   // Present a request and return right after its accept edge (lat = 1)
   task automatic issue(input int p, input int s, input int l);
      int g;
      g = 0;
      @(negedge clk);
      req_pass = 2'(p); req_start = 7'(s); req_len = 7'(l); req_valid = 1'b1;
      while (!req_ready && g < 20) begin
         @(negedge clk);
         g++;
      end
      check("issue_req_ready", 32'(req_ready), 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1;
   endtask

   task automatic wait_rsp(input string tag, input int par, input int err, input int pass, input int exp_lat);
      while (!rsp_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, "_lat"},    32'(lat), 32'(exp_lat));
      check({tag, "_parity"}, 32'(rsp_parity), 32'(par));
      check({tag, "_err"},    32'(rsp_err), 32'(err));
      check({tag, "_pass"},   32'(rsp_pass), 32'(pass));
   endtask

   task automatic ack();
      @(negedge clk);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check("ack_valid_low", 32'(rsp_valid), 0);
      check("ack_key_ready", 32'(key_ready), 1);
   endtask

   task automatic run_vec(input string tag, input int p, input int s, input int l,
                          input int par, input int err, input int exp_lat);
      issue(p, s, l);
      wait_rsp(tag, par, err, p, exp_lat);
      ack();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_valid_low", 32'(rsp_valid), 0);
      check("rst_parity_low", 32'(rsp_parity), 0);
      check("rst_err_low", 32'(rsp_err), 0);
      check("rst_pass_low", 32'(rsp_pass), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_key_ready", 32'(key_ready), 1);
      check("post_rst_req_ready", 32'(req_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; key_load = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      key_p1 = '0; key_p2 = '0; key_p3 = '0; key_p4 = '0;
      req_pass = '0; req_start = '0; req_len = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(rsp_valid), 0);
      check("reset_parity", 32'(rsp_parity), 0);
      check("reset_err", 32'(rsp_err), 0);
      check("reset_pass", 32'(rsp_pass), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_key_ready", 32'(key_ready), 1);
      check("idle_req_ready", 32'(req_ready), 1);

      load_keys(64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0100,
                64'h8000_0000_0000_0001, 64'h0000_0000_0000_0007);

      // Legal ranges: tag, pass, start, len, parity, err, latency
      run_vec("p0_0_8",   0, 0, 8, 0, 0, 2);
      run_vec("p0_4_5",   0, 4, 5, 0, 0, 2);
      run_vec("p0_4_3",   0, 4, 3, 1, 0, 2);
      run_vec("p0_3_1",   0, 3, 1, 1, 0, 2);
      run_vec("p0_0_64",  0, 0, 64, 0, 0, 9);
      run_vec("p1_1_9",   1, 1, 9, 1, 0, 3);
      run_vec("p1_0_8",   1, 0, 8, 0, 0, 2);
      run_vec("p2_0_64",  2, 0, 64, 0, 0, 9);
      run_vec("p2_63_1",  2, 63, 1, 1, 0, 2);
      run_vec("p2_56_8",  2, 56, 8, 1, 0, 2);
      run_vec("p3_0_2",   3, 0, 2, 0, 0, 2);
      run_vec("p3_2_62",  3, 2, 62, 1, 0, 9);

      // Range errors
      run_vec("err_60_5",  1, 60, 5, 0, 1, 1);
      run_vec("err_len0",  3, 10, 0, 0, 1, 1);
      run_vec("err_64_1",  2, 64, 1, 0, 1, 1);
      run_vec("err_0_65",  0, 0, 65, 0, 1, 1);

      // Response held under backpressure
      issue(2, 63, 1);
      wait_rsp("hold", 1, 0, 2, 2);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("hold_valid", 32'(rsp_valid), 1);
         check("hold_parity", 32'(rsp_parity), 1);
         check("hold_pass", 32'(rsp_pass), 2);
         check("hold_req_ready", 32'(req_ready), 0);
      end
      ack();

      // key_load during CALC is ignored
      issue(2, 0, 64);
      @(negedge clk);
      key_p3 = 64'h0000_0000_0000_0001; key_p2 = '0;
      key_load = 1'b1;
      #1;
      check("calc_key_ready", 32'(key_ready), 0);
      check("calc_req_ready", 32'(req_ready), 0);
      @(posedge clk); #1;
      lat++;
      key_load = 1'b0;
      wait_rsp("calc_load", 0, 0, 2, 9);
      ack();
      run_vec("keep_p2_63_1", 2, 63, 1, 1, 0, 2);
      run_vec("keep_p1_1_9",  1, 1, 9, 1, 0, 3);

      // Reset mid-CALC clears the snapshot
      issue(3, 2, 62);
      @(posedge clk); #1;
      do_reset();
      run_vec("zero_p3_2_62", 3, 2, 62, 0, 0, 9);
      run_vec("zero_p1_1_9",  1, 1, 9, 0, 0, 3);
      run_vec("zero_err",     0, 0, 0, 0, 1, 1);
`ifdef CASCADE_QUERY_CNT_EN
      check("query_cnt_3", 32'(query_cnt), 3);
`endif
      load_keys(64'h0000_0000_0000_00FF, '0, '0, '0);
`ifdef CASCADE_QUERY_CNT_EN
      check("query_cnt_clr", 32'(query_cnt), 0);
`endif

      // Reset while a response is pending drops it at once
      issue(0, 0, 7);
      wait_rsp("pre_rst", 1, 0, 0, 2);
      do_reset();
      run_vec("after_rst_p0", 0, 0, 8, 0, 0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
